// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Mode values select what happens at the count limits.
package counter_pkg;

    localparam int unsigned CNT_WRAP      = 0;
    localparam int unsigned CNT_SAT       = 1;
    localparam int unsigned CNT_MAX_WIDTH = 32;

    // Any value outside 0..modulus-1 maps to the top of the range.
    function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                               input logic [63:0] modulus);
        return (value < modulus) ? value : (modulus - 64'd1);
    endfunction

endpackage

// File: rtl/cnt_next.sv
// Next-state logic for mod_counter: decides the next count, the overflow
// event and the terminal-count prediction. Purely combinational.
module cnt_next
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter longint unsigned  MODULUS  = 16,
    parameter int unsigned      SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             ovf_next,
    output logic             tc
);

    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 64'd1);
    localparam logic             SAT_MODE = (SATURATE == CNT_SAT);

    logic [WIDTH:0]   w_q_inc;
    logic [WIDTH:0]   w_q_dec;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_load_q;

    // The extra bit makes both limit tests fall out of the adders:
    // incrementing onto MODULUS means top of range, a borrow means zero.
    assign w_q_inc   = {1'b0, q} + (WIDTH+1)'(1);
    assign w_q_dec   = {1'b0, q} - (WIDTH+1)'(1);
    assign w_at_max  = (w_q_inc == MOD_EXT);
    assign w_at_zero = w_q_dec[WIDTH];
    assign w_load_q  = WIDTH'(clamp_load(64'(load_val), 64'(MODULUS)));

    assign tc = en & ~clr & ~load & (up ? w_at_max : w_at_zero);

    always_comb begin
        q_next   = q;
        ovf_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = w_load_q;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    ovf_next = 1'b1;
                    q_next   = SAT_MODE ? q : '0;
                end else begin
                    q_next = w_q_inc[WIDTH-1:0];
                end
            end else begin
                if (w_at_zero) begin
                    ovf_next = 1'b1;
                    q_next   = SAT_MODE ? q : Q_MAX;
                end else begin
                    q_next = w_q_dec[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Synchronous modulo-N up/down counter with clear, load, wrap/saturate mode,
// terminal-count and overflow flags. Holds only the count and ovf registers.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter longint unsigned  MODULUS  = 16,
    parameter int unsigned      SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;

    generate
        if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
            $error("mod_counter: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
            $error("mod_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ovf_next;
    logic             w_tc;

    cnt_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_cnt_next (
        .q        (r_q),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_next   (w_q_next),
        .ovf_next (w_ovf_next),
        .tc       (w_tc)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign q   = r_q;
    assign ovf = r_ovf;
    assign tc  = w_tc;

endmodule

// File: tb/tb_mod_counter.sv
// Directed-vector bench for mod_counter: wrap and saturate instances share
// stimulus, plus a MODULUS=2 instance and a two-stage BCD cascade.
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en, up, clr, load;
    logic [3:0] lv;
    logic       c_en, c_clr;

    logic [3:0] wq, sq, lq, hq;
    logic [0:0] mq;
    logic       wtc, wovf, stc, sovf, mtc, movf, ltc, lovf, htc, hovf;

    int unsigned n_vec;
    int unsigned n_err;

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_wrap (
        .clk(clk), .rst_(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .q(wq), .tc(wtc), .ovf(wovf)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_SAT)) u_sat (
        .clk(clk), .rst_(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .q(sq), .tc(stc), .ovf(sovf)
    );

    mod_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(CNT_WRAP)) u_m2 (
        .clk(clk), .rst_(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[0:0]), .q(mq), .tc(mtc), .ovf(movf)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_lo (
        .clk(clk), .rst_(rst_n), .en(c_en), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(lq), .tc(ltc), .ovf(lovf)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_hi (
        .clk(clk), .rst_(rst_n), .en(ltc), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(hq), .tc(htc), .ovf(hovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv = 4'd0;
        c_en = 1'b0; c_clr = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_wq", 32'(wq), 0);
        check("rst_wovf", 32'(wovf), 0);
        check("rst_sq", 32'(sq), 0);
        check("rst_wtc", 32'(wtc), 0);
        rst_n = 1'b1;

        // reset mid-count at q=7
        load = 1'b1; lv = 4'd6;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        check("mid_q7", 32'(wq), 7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_q", 32'(wq), 0);
        check("mid_async_ovf", 32'(wovf), 0);
        tick();
        check("mid_hold_q", 32'(wq), 0);
        check("mid_hold_sq", 32'(sq), 0);
        rst_n = 1'b1;

        // up count: wrap instance wraps, saturate instance sticks at 9
        check("up_tc0", 32'(wtc), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("up_wq", 32'(wq), 32'(i % 10));
            check("up_wovf", 32'(wovf), (i == 10) ? 1 : 0);
            check("up_wtc", 32'(wtc), ((i % 10) == 9) ? 1 : 0);
            check("up_sq", 32'(sq), (i < 9) ? 32'(i) : 9);
            check("up_sovf", 32'(sovf), (i >= 10) ? 1 : 0);
        end

        // down from 1
        en = 1'b0; load = 1'b1; lv = 4'd1;
        tick();
        check("dn_ld_wq", 32'(wq), 1);
        check("dn_ld_sq", 32'(sq), 1);
        check("dn_ld_sovf", 32'(sovf), 0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        check("dn1_wq", 32'(wq), 0);
        check("dn1_wovf", 32'(wovf), 0);
        check("dn1_wtc", 32'(wtc), 1);
        check("dn1_sq", 32'(sq), 0);
        check("dn1_stc", 32'(stc), 1);
        tick();
        check("dn2_wq", 32'(wq), 9);
        check("dn2_wovf", 32'(wovf), 1);
        check("dn2_wtc", 32'(wtc), 0);
        check("dn2_sq", 32'(sq), 0);
        check("dn2_sovf", 32'(sovf), 1);
        check("dn2_stc", 32'(stc), 1);
        tick();
        check("dn3_wq", 32'(wq), 8);
        check("dn3_wovf", 32'(wovf), 0);
        check("dn3_sq", 32'(sq), 0);
        check("dn3_sovf", 32'(sovf), 1);

        // priority clr > load > en
        en = 1'b0; load = 1'b1; lv = 4'd5;
        tick();
        check("pri_q5", 32'(wq), 5);
        clr = 1'b1; load = 1'b1; lv = 4'd3; en = 1'b1; up = 1'b1;
        tick();
        check("pri_clr", 32'(wq), 0);
        check("pri_clr_s", 32'(sq), 0);
        clr = 1'b0;
        tick();
        check("pri_load", 32'(wq), 3);
        load = 1'b0;
        tick();
        check("pri_en", 32'(wq), 4);

        // load clamp, and tc masked by load / clr
        en = 1'b0; load = 1'b1; lv = 4'd14;
        tick();
        check("clamp14", 32'(wq), 9);
        check("clamp14_ovf", 32'(wovf), 0);
        en = 1'b1; up = 1'b1; lv = 4'd9;
        #1;
        check("tc_load_mask", 32'(wtc), 0);
        tick();
        check("clamp9", 32'(wq), 9);
        check("clamp9_ovf", 32'(wovf), 0);
        lv = 4'd0;
        tick();
        check("clamp0", 32'(wq), 0);
        check("clamp0_ovf", 32'(wovf), 0);
        load = 1'b0; up = 1'b0;
        #1;
        check("tc_dn_zero", 32'(wtc), 1);
        clr = 1'b1;
        #1;
        check("tc_clr_mask", 32'(wtc), 0);
        tick();
        check("clr_ovf", 32'(wovf), 0);
        clr = 1'b0; en = 1'b0; load = 1'b1; lv = 4'd4;
        tick();
        load = 1'b0;
        tick();
        check("hold_q", 32'(wq), 4);
        check("hold_ovf", 32'(wovf), 0);

        // MODULUS=2: ovf every other cycle
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        check("m2_q0", 32'(mq), 0);
        check("m2_tc0", 32'(mtc), 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("m2_q", 32'(mq), 32'(i % 2));
            check("m2_ovf", 32'(movf), ((i % 2) == 0) ? 1 : 0);
            check("m2_tc", 32'(mtc), 32'(i % 2));
        end
        en = 1'b0;

        // BCD cascade
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0; c_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            check("cas_lo", 32'(lq), 32'((i % 100) % 10));
            check("cas_hi", 32'(hq), 32'((i % 100) / 10));
            check("cas_hovf", 32'(hovf), (i == 100) ? 1 : 0);
        end
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
